// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO slice.
//   DEF_WIDTH / DEF_DEPTH : default data width and entry count.
//   ptr_w(depth)          : pointer width, one extra MSB beyond the address
//                           so that full and empty can be told apart.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/synchronous_fifo_if.sv
// Handshake bundle between a FIFO user (master) and the FIFO (slave).
//   cs, wr_enb, rd_enb, data_in : driven by the master
//   data_out, full, empty       : driven by the FIFO
interface synchronous_fifo_if #(
  parameter int WIDTH = fifo_pkg::DEF_WIDTH
);

  logic             cs;
  logic             wr_enb;
  logic             rd_enb;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  modport master (
    output cs, wr_enb, rd_enb, data_in,
    input  data_out, full, empty
  );

  modport slave (
    input  cs, wr_enb, rd_enb, data_in,
    output data_out, full, empty
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and one synchronous
// read port. The read port register is the FIFO's data_out and is the only
// part cleared by reset; the array itself is never cleared.
//   clk, rst       : clock, synchronous active-high reset (read register only)
//   we, waddr, wdata : write port
//   re, raddr, rdata : read port, rdata registered and held when re = 0
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with registered read data and no read-through bypass.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset; clears pointers and data_out
//   bus  : slave side of synchronous_fifo_if
//          cs gates everything; wr_enb/rd_enb request a write/read;
//          full/empty are combinational from the registered pointers.
// DEPTH must be a power of two, >= 2.
module synchronous_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic               clk,
  input logic               rst,
  synchronous_fifo_if.slave bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          wr_acc;
  logic          rd_acc;

  // Extra pointer MSB distinguishes a full wrap from an empty FIFO.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign wr_acc = bus.cs && bus.wr_enb && !full;
  assign rd_acc = bus.cs && bus.rd_enb && !empty;

  assign bus.full  = full;
  assign bus.empty = empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Reset wins over a concurrent write so the array is left untouched.
  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc && !rst),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.data_in),
    .re    (rd_acc),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (bus.data_out)
  );

endmodule

// File: tb/tb_synchronous_fifo.sv
module tb_synchronous_fifo;

  logic clk;
  logic rst;

  synchronous_fifo_if #(.WIDTH(8)) bus ();

  synchronous_fifo #(.WIDTH(8), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       cs;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t vq[$];
  int   n_vec;
  int   n_err;

  task automatic add(input logic r, input logic c, input logic w, input logic rd,
                     input logic [7:0] d, input logic [7:0] edo,
                     input logic ef, input logic ee);
    vec_t v;
    v.rst = r; v.cs = c; v.wr = w; v.rd = rd; v.din = d;
    v.dout = edo; v.full = ef; v.empty = ee;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, input logic c, input logic w, input logic rd,
                       input logic [7:0] d);
    rst = r; bus.cs = c; bus.wr_enb = w; bus.rd_enb = rd; bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got dout=%02h full=%b empty=%b, want dout=%02h full=%b empty=%b",
               name, act[9:2], act[1], act[0], exp[9:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    int wcount;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; bus.cs = 1'b0; bus.wr_enb = 1'b0; bus.rd_enb = 1'b0; bus.data_in = 8'h00;

    // Reset and idle
    add(1, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    // Three writes, three reads
    add(0, 1, 1, 0, 8'hA1, 8'h00, 0, 0);
    add(0, 1, 1, 0, 8'hB2, 8'h00, 0, 0);
    add(0, 1, 1, 0, 8'hC3, 8'h00, 0, 0);
    add(0, 1, 0, 1, 8'h00, 8'hA1, 0, 0);
    add(0, 1, 0, 1, 8'h00, 8'hB2, 0, 0);
    add(0, 1, 0, 1, 8'h00, 8'hC3, 0, 1);
    // Underflow attempt and cs = 0 freeze
    add(0, 1, 0, 1, 8'h00, 8'hC3, 0, 1);
    add(0, 0, 1, 0, 8'h55, 8'hC3, 0, 1);
    add(0, 0, 0, 1, 8'h00, 8'hC3, 0, 1);
    // Fill to full, overflow attempt, drain
    for (int i = 0; i < 8; i++) add(0, 1, 1, 0, 8'(i), 8'hC3, (i == 7), 0);
    add(0, 1, 1, 0, 8'hFF, 8'hC3, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 1, 8'h00, 8'(i), 0, (i == 7));
    // Read+write while empty: write only
    add(0, 1, 1, 1, 8'h77, 8'h07, 0, 0);
    add(0, 1, 0, 1, 8'h00, 8'h77, 0, 1);
    // Wrap: write 6, read 6, write 8
    for (int i = 0; i < 6; i++) add(0, 1, 1, 0, 8'h20 + 8'(i), 8'h77, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 1, 0, 1, 8'h00, 8'h20 + 8'(i), 0, (i == 5));
    for (int i = 0; i < 8; i++) add(0, 1, 1, 0, 8'h10 + 8'(i), 8'h25, (i == 7), 0);
    // Read+write while full: read only
    add(0, 1, 1, 1, 8'hEE, 8'h10, 0, 0);
    for (int i = 1; i < 8; i++) add(0, 1, 0, 1, 8'h00, 8'h10 + 8'(i), 0, (i == 7));
    // Four entries, then five cycles of simultaneous read and write
    for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 8'h30 + 8'(i), 8'h17, 0, 0);
    add(0, 1, 1, 1, 8'h40, 8'h30, 0, 0);
    add(0, 1, 1, 1, 8'h41, 8'h31, 0, 0);
    add(0, 1, 1, 1, 8'h42, 8'h32, 0, 0);
    add(0, 1, 1, 1, 8'h43, 8'h33, 0, 0);
    add(0, 1, 1, 1, 8'h44, 8'h40, 0, 0);
    // Reset mid-stream overrides the concurrent access and discards entries
    add(1, 1, 1, 1, 8'h99, 8'h00, 0, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    add(0, 1, 0, 1, 8'h00, 8'h00, 0, 1);

    foreach (vq[k]) begin
      drive(vq[k].rst, vq[k].cs, vq[k].wr, vq[k].rd, vq[k].din);
      check($sformatf("vec%0d", k), {bus.data_out, bus.full, bus.empty},
            {vq[k].dout, vq[k].full, vq[k].empty});
    end

    // cs = 0 must hold a stored entry in place across read requests
    drive(0, 1, 1, 0, 8'h5A);
    check("hold_wr", {bus.data_out, bus.full, bus.empty}, {8'h00, 1'b0, 1'b0});
    drive(0, 0, 0, 1, 8'h00);
    check("hold_cs0_a", {bus.data_out, bus.full, bus.empty}, {8'h00, 1'b0, 1'b0});
    drive(0, 0, 1, 1, 8'h66);
    check("hold_cs0_b", {bus.data_out, bus.full, bus.empty}, {8'h00, 1'b0, 1'b0});
    drive(0, 1, 0, 1, 8'h00);
    check("hold_rd", {bus.data_out, bus.full, bus.empty}, {8'h5A, 1'b0, 1'b1});

    // Write until full with a bounded cycle budget; capacity must be 8
    wcount = 0;
    for (int c = 0; c < 16 && !bus.full; c++) begin
      drive(0, 1, 1, 0, 8'h80 + 8'(wcount));
      wcount++;
    end
    n_vec++;
    if (wcount != 8 || !bus.full) begin
      n_err++;
      $display("FAIL fill_count: got %0d writes full=%b, want 8 writes full=1", wcount, bus.full);
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 1, 8'h00);
      check($sformatf("drain%0d", i), {bus.data_out, bus.full, bus.empty},
            {8'h80 + 8'(i), 1'b0, (i == 7)});
    end

    drive(0, 0, 0, 0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/synchronous_fifo.md
SYNCHRONOUS_FIFO -- requirements
Module: synchronous_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of storage entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cs  input  1  chip select; when 0, no read or write takes effect.
REQ-006 wr_enb  input  1  write request.
REQ-007 rd_enb  input  1  read request.
REQ-008 data_in  input  WIDTH  write data.
REQ-009 data_out  output  WIDTH  read data, registered.
REQ-010 full  output  1  high when DEPTH entries are stored.
REQ-011 empty  output  1  high when no entries are stored.

Function
REQ-012 Write accept = cs & wr_enb & !full, sampled at the rising edge; data_in is stored at the write-pointer location and the write pointer increments.
REQ-013 Read accept = cs & rd_enb & !empty; the entry at the read pointer is loaded into data_out at that edge and the read pointer increments; data_out is valid from the cycle after the request.
REQ-014 data_out holds its last value on every cycle without a read accept.
REQ-015 Pointers are log2(DEPTH)+1 bits; the low bits address memory and wrap from DEPTH-1 to 0; the MSB toggles on wrap.
REQ-016 empty = (wr_ptr == rd_ptr); full = (MSBs differ) & (low bits equal); both flags are combinational from the registered pointers.
REQ-017 Write while full: ignored; memory and pointers are unchanged (no overflow).
REQ-018 Read while empty: ignored; data_out and pointers are unchanged (no underflow).
REQ-019 Simultaneous read and write when neither is blocked: both occur in the same cycle and occupancy is unchanged.
REQ-020 Simultaneous read and write while full: the read occurs and the write is ignored.
REQ-021 Simultaneous read and write while empty: the write occurs and the read is ignored.
REQ-022 Ordering is strictly first-in first-out; there is no read-through bypass, so a word written at cycle N is readable at the earliest at cycle N+1.
REQ-023 cs = 0 freezes all state regardless of wr_enb and rd_enb.

Reset
REQ-024 When rst = 1 at a rising edge: wr_ptr = 0, rd_ptr = 0, data_out = 0; consequently empty = 1 and full = 0.
REQ-025 Reset overrides any concurrent read or write; memory contents are not cleared.
REQ-026 Reset asserted mid-operation discards all stored entries.

Structure
REQ-027 A shared package fifo_pkg holds the default WIDTH and DEPTH constants and a derived pointer-width function or constant, clog2(DEPTH)+1.
REQ-028 Storage is a sub-module fifo_mem (DEPTH x WIDTH, one synchronous write port and one synchronous read port); pointer and flag logic stays in synchronous_fifo.

Verification
REQ-029 Reset, then idle: after rst is high for 1 edge -> empty = 1, full = 0, data_out = 0.
REQ-030 With cs = 1, write 8'hA1, 8'hB2, 8'hC3, then read 3 times -> data_out shows A1, B2, C3 on the successive cycles after each read, then empty = 1.
REQ-031 Write 8 words 0x00..0x07 -> full = 1 after the 8th write; a 9th write of 0xFF is ignored; 8 reads return 0x00..0x07 in order.
REQ-032 Read when empty -> data_out keeps its previous value and empty stays 1; with cs = 0, a write of 0x55 leaves empty = 1.
REQ-033 Wrap: write 6, read 6, write 8 (0x10..0x17) -> full = 1; the reads return 0x10..0x17 in order.
REQ-034 With the FIFO holding 4 entries, assert read and write together for 5 cycles -> occupancy stays 4 and full and empty stay 0; assert rst mid-stream -> empty = 1 on the next cycle.
